ternary_mac_array: RTL and testbench
====================================

# ternary_mac_array

Parametrised 1.58-bit (ternary-weight) matrix-multiply core, successor to the fixed 8x2 systolic array behind the TinyTapeout top. It accumulates rank-1 products of a ternary weight column vector and an integer activation row vector, delivered in time-multiplexed slices. Read-out is an explicit valid/ready stream with arithmetic shift, optional ReLU and saturation, so it can drain while the next tile accumulates. Read-out also supports signed and unsigned activations.

## Interface
Parameters:
- SLICES, 2: beats per complete input vector set; total rows H = ROWS*SLICES, cols W = COLS*SLICES
- ROWS, 4: ternary weights per beat
- COLS, 1: activations per beat
- IN_W, 8: activation width
- ACC_W, 17: accumulator width, signed
- OUT_W, 8: output width, signed

Ports:
- Single clock, clk; reset is synchronous and active-high, named reset.
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_weights  in  2*ROWS  packed ternary, 2 bits per row; 00 = 0, 01 = +1, 1x = -1
- in_data  in  COLS*IN_W  activations for this slice
- in_data_signed  in  1  1: in_data two's complement; 0: unsigned (zero-extended)
- in_valid  in  1  beat present; no input backpressure
- clear  in  1  zero accumulators, discard partial slice set
- start_readout  in  1  snapshot accumulators into out queue, zero accumulators, begin drain
- shift  in  $clog2(ACC_W)  arithmetic right shift applied at output, sampled at start_readout
- relu  in  1  clamp negatives to 0, sampled at start_readout
- out_data  out  OUT_W  post-processed result
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts
- out_last  out  1  marks element H*W-1
- readout_overrun  out  1  one-cycle pulse: start_readout ignored (drain in progress)

## Operation
- Slice counter s (0..SLICES-1) advances on each in_valid beat and wraps. Beat s loads weights for rows s*ROWS.. and activations for cols s*COLS.. into staging.
- On the beat with s = SLICES-1, the compute uses staging plus the current beat. Every accumulator updates in the same edge: acc[i][j] += w_i * x_j, i.e. add, subtract or hold. Addend is sign- or zero-extended per in_data_signed. Accumulators wrap modulo 2^ACC_W.
- FSM: ACCUM (reset state) and DRAIN.
  - ACCUM + start_readout: snapshot = acc_next, which includes a compute completing that cycle. Then acc <= 0, s <= 0, shift and relu latched, go to DRAIN, index n = 0.
  - DRAIN: out_data = post(snapshot[n]) with n = i*W + j. Index advances on out_valid & out_ready. Leaving DRAIN happens on acceptance of n = H*W-1.
  - Accumulation continues in DRAIN.
  - start_readout in DRAIN is ignored; readout_overrun pulses.
- Post-processing: v = snap >>> shift; if relu and v<0 then v=0; saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- clear: acc <= 0 and s <= 0; an in_valid beat in the same cycle is discarded. If clear coincides with start_readout, the readout takes priority for the snapshot; both zero the accumulators.
- A partial slice set is discarded by clear or start_readout.
- reset: acc, staging, s, n all 0; FSM to ACCUM; out_valid, out_last, out_data, readout_overrun all 0.

## Timing
- Input accepted every cycle. The accumulator update is visible at the edge of the SLICES-th beat (zero extra latency).
- out_valid rises the cycle after the start_readout edge. It holds with stable out_data until accepted.
- At full throughput, one element per cycle, H*W cycles.
- out_valid drops the cycle after the last acceptance. The earliest next start_readout is in that same cycle.
- Reset mid-drain: out_valid 0 on the next cycle and the queue is abandoned.

## Structure
- Package ternary_mac_pkg holds:
  - ternary encoding constants
  - function decoding 2 bits to {zero, sign}
  - saturate function
  - localparams H, W
- Sub-module ternary_postproc (shift/ReLU/saturate, combinational) is instantiated once on the queue output mux.
- Accumulator array, staging and FSM live in the top module.

## Test plan
Defaults: H=8, W=2, 16 outputs.
1. Reset, then start_readout with out_ready=1 -> 16 beats of 0; out_last on the 16th; out_valid low afterwards.
2. Input beats:
   - Beat 0: weights 8'b01010101, data 10.
   - Beat 1: weights 8'b11111111, data 20.
   - Then start_readout, shift=0, relu=0.
   - Required output: rows 0-3 give 10,20 each; rows 4-7 give -10,-20 each (0xF6, 0xEC).
3. Same data with shift=2, relu=1 -> rows 0-3 give 2,5; rows 4-7 give 0,0.
4. Saturation and unsigned mode:
   - 20 sets of data 127 with weight +1 on row 0 and -1 on row 4 -> outputs 127 and -128.
   - Unsigned data 0xFF, shift=1 -> 127.
5. Backpressure and overrun:
   - out_ready low for 5 cycles at n=3 -> out_data stable, no index skipped.
   - start_readout during drain -> readout_overrun pulse, stream unaffected.
   - New sets issued during drain appear in the next readout.
6. Boundary cases:
   - clear after beat 0 -> a subsequent full set computes as if fresh.
   - start_readout coinciding with the SLICES-th beat -> contribution included, next readout 0.
   - Reset at n=5 -> out_valid 0 next cycle.

Source files
------------

// File: rtl/ternary_mac_pkg.sv
// Shared types, ternary weight decoding and output saturation for the ternary MAC array.
package ternary_mac_pkg;

  localparam int unsigned SLICES_DEF = 2;
  localparam int unsigned ROWS_DEF   = 4;
  localparam int unsigned COLS_DEF   = 1;
  localparam int unsigned H          = ROWS_DEF * SLICES_DEF;
  localparam int unsigned W          = COLS_DEF * SLICES_DEF;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b10;

  typedef struct packed {
    logic zero;
    logic neg;
  } tern_t;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Any code with the top bit set is -1; 00 is zero, 01 is +1.
  function automatic tern_t tern_decode(input logic [1:0] code);
    tern_t t;
    t.neg  = (code[1] == TERN_NEG[1]);
    t.zero = (code == TERN_ZERO) || ((code != TERN_POS) && !t.neg);
    return t;
  endfunction

  function automatic longint saturate(input longint v, input int unsigned out_w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (out_w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/ternary_postproc.sv
// Output stage: arithmetic right shift, optional ReLU, signed saturation to OUT_W.
module ternary_postproc
  import ternary_mac_pkg::*;
#(
  parameter int unsigned ACC_W = 17,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned SH_W  = $clog2(ACC_W)
) (
  input  logic [ACC_W-1:0] value,
  input  logic [SH_W-1:0]  shift,
  input  logic             relu,
  output logic [OUT_W-1:0] result_c
);

  longint v;

  always_comb begin
    v = 64'($signed(value)) >>> shift;
    if (relu && (v < 0)) v = 0;
    result_c = OUT_W'(saturate(v, OUT_W));
  end

endmodule

// File: rtl/ternary_mac_array.sv
// Ternary-weight rank-1 accumulate array with sliced input and a valid/ready drain queue.
module ternary_mac_array
  import ternary_mac_pkg::*;
#(
  parameter int unsigned SLICES = SLICES_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned COLS   = COLS_DEF,
  parameter int unsigned IN_W   = 8,
  parameter int unsigned ACC_W  = 17,
  parameter int unsigned OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*ROWS-1:0]        in_weights,
  input  logic [COLS*IN_W-1:0]     in_data,
  input  logic                     in_data_signed,
  input  logic                     in_valid,
  input  logic                     clear,
  input  logic                     start_readout,
  input  logic [$clog2(ACC_W)-1:0] shift,
  input  logic                     relu,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     readout_overrun
);

  localparam int unsigned NUM_ROWS      = ROWS * SLICES;
  localparam int unsigned NUM_COLS      = COLS * SLICES;
  localparam int unsigned NUM_OUT       = NUM_ROWS * NUM_COLS;
  localparam int unsigned SH_W          = $clog2(ACC_W);
  localparam int unsigned S_W           = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned N_W           = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;
  localparam int unsigned LAST_ROW_BASE = (SLICES - 1) * ROWS;
  localparam int unsigned LAST_COL_BASE = (SLICES - 1) * COLS;

  logic signed [ACC_W-1:0] acc_q   [NUM_OUT];
  logic signed [ACC_W-1:0] acc_d   [NUM_OUT];
  logic signed [ACC_W-1:0] snap_q  [NUM_OUT];
  logic [1:0]              w_stage_q [NUM_ROWS];
  logic signed [IN_W:0]    x_stage_q [NUM_COLS];
  logic [1:0]              w_cur   [NUM_ROWS];
  logic signed [IN_W:0]    x_cur   [NUM_COLS];
  logic signed [IN_W:0]    x_beat  [COLS];

  state_e            state_q, state_d;
  logic [S_W-1:0]    s_q;
  logic [N_W-1:0]    n_q, n_d;
  logic [SH_W-1:0]   shift_q, sel_shift;
  logic              relu_q, sel_relu;
  logic              fire, start_acc, valid_d, last_d, overrun_d;
  logic [ACC_W-1:0]  sel_value;
  logic [OUT_W-1:0]  post_c, data_d;

  // Current-beat activations extended to a signed addend.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      x_beat[c] = in_data_signed ? $signed({in_data[c*IN_W+IN_W-1], in_data[c*IN_W +: IN_W]})
                                 : $signed({1'b0, in_data[c*IN_W +: IN_W]});
    end
  end

  // Staged slices plus the final beat form the full vectors; accumulate on the final beat.
  always_comb begin
    tern_t                   t;
    logic signed [ACC_W-1:0] addend;
    for (int i = 0; i < NUM_ROWS; i++) w_cur[i] = w_stage_q[i];
    for (int j = 0; j < NUM_COLS; j++) x_cur[j] = x_stage_q[j];
    for (int r = 0; r < ROWS; r++) w_cur[LAST_ROW_BASE + r] = in_weights[2*r +: 2];
    for (int c = 0; c < COLS; c++) x_cur[LAST_COL_BASE + c] = x_beat[c];
    fire = in_valid && !clear && (s_q == S_W'(SLICES - 1));
    for (int i = 0; i < NUM_ROWS; i++) begin
      t = tern_decode(w_cur[i]);
      for (int j = 0; j < NUM_COLS; j++) begin
        addend = ACC_W'(x_cur[j]);
        acc_d[i*NUM_COLS + j] = acc_q[i*NUM_COLS + j];
        if (fire && !t.zero) begin
          acc_d[i*NUM_COLS + j] = t.neg ? acc_q[i*NUM_COLS + j] - addend
                                        : acc_q[i*NUM_COLS + j] + addend;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    valid_d   = 1'b0;
    overrun_d = 1'b0;
    start_acc = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        if (start_readout) begin
          start_acc = 1'b1;
          state_d   = ST_DRAIN;
          n_d       = '0;
          valid_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        valid_d   = 1'b1;
        overrun_d = start_readout;
        if (out_ready) begin
          if (n_q == N_W'(NUM_OUT - 1)) begin
            state_d = ST_ACCUM;
            valid_d = 1'b0;
          end else begin
            n_d = n_q + N_W'(1);
          end
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    last_d = valid_d && (n_d == N_W'(NUM_OUT - 1));
  end

  // The registered output is computed from the element that will be presented next.
  always_comb begin
    sel_value = start_acc ? acc_d[0] : snap_q[n_d];
    sel_shift = start_acc ? shift : shift_q;
    sel_relu  = start_acc ? relu : relu_q;
  end

  ternary_postproc #(
    .ACC_W (ACC_W),
    .OUT_W (OUT_W),
    .SH_W  (SH_W)
  ) u_postproc (
    .value    (sel_value),
    .shift    (sel_shift),
    .relu     (sel_relu),
    .result_c (post_c)
  );

  assign data_d = valid_d ? post_c : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_ACCUM;
      s_q             <= '0;
      n_q             <= '0;
      shift_q         <= '0;
      relu_q          <= 1'b0;
      out_data        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      readout_overrun <= 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
        acc_q[k]  <= '0;
        snap_q[k] <= '0;
      end
      for (int i = 0; i < NUM_ROWS; i++) w_stage_q[i] <= '0;
      for (int j = 0; j < NUM_COLS; j++) x_stage_q[j] <= '0;
    end else begin
      state_q         <= state_d;
      n_q             <= n_d;
      out_data        <= data_d;
      out_valid       <= valid_d;
      out_last        <= last_d;
      readout_overrun <= overrun_d;
      if (clear || start_acc) begin
        s_q <= '0;
      end else if (in_valid) begin
        s_q <= (s_q == S_W'(SLICES - 1)) ? '0 : s_q + S_W'(1);
      end
      for (int k = 0; k < NUM_OUT; k++) begin
        acc_q[k] <= (clear || start_acc) ? '0 : acc_d[k];
        if (start_acc) snap_q[k] <= acc_d[k];
      end
      if (start_acc) begin
        shift_q <= shift;
        relu_q  <= relu;
      end
      if (in_valid && !clear) begin
        for (int i = 0; i < NUM_ROWS; i++) begin
          if (S_W'(i / ROWS) == s_q) w_stage_q[i] <= in_weights[2*(i % ROWS) +: 2];
        end
        for (int j = 0; j < NUM_COLS; j++) begin
          if (S_W'(j / COLS) == s_q) x_stage_q[j] <= x_beat[j % COLS];
        end
      end
    end
  end

endmodule

// File: tb/tb_ternary_mac_array.sv
// Directed bench for ternary_mac_array with hand-computed expected drain streams.
module tb_ternary_mac_array;
  import ternary_mac_pkg::*;

  localparam int unsigned N = H * W;

  logic       clk;
  logic       reset;
  logic [7:0] in_weights;
  logic [7:0] in_data;
  logic       in_data_signed;
  logic       in_valid;
  logic       clear;
  logic       start_readout;
  logic [4:0] shift;
  logic       relu;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       readout_overrun;

  int checks;
  int errors;

  int zeros [N];
  int e2    [N];
  int e3    [N];
  int e4    [N];
  int e4b   [N];
  int e5n   [N];

  ternary_mac_array dut (
    .clk             (clk),
    .reset           (reset),
    .in_weights      (in_weights),
    .in_data         (in_data),
    .in_data_signed  (in_data_signed),
    .in_valid        (in_valid),
    .clear           (clear),
    .start_readout   (start_readout),
    .shift           (shift),
    .relu            (relu),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_last        (out_last),
    .readout_overrun (readout_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] w, input logic [7:0] d, input logic sgn);
    in_valid       = 1'b1;
    in_weights     = w;
    in_data        = d;
    in_data_signed = sgn;
    step();
    in_valid       = 1'b0;
  endtask

  task automatic start_ro(input int sh, input logic rl);
    start_readout = 1'b1;
    shift         = 5'(sh);
    relu          = rl;
    step();
    start_readout = 1'b0;
  endtask

  // Walks the whole queue; optional stall, overrun request and a new set fed mid-drain.
  task automatic drain(input string tag, input int exp_v [N], input int stall_at,
                       input int ov_at, input bit feed);
    for (int n = 0; n < int'(N); n++) begin
      if (n == stall_at) begin
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
          step();
          check($sformatf("%s stall data n%0d", tag, n), $signed(out_data), exp_v[n]);
          check($sformatf("%s stall valid n%0d", tag, n), int'(out_valid), 1);
        end
        out_ready = 1'b1;
      end
      check($sformatf("%s data n%0d", tag, n), $signed(out_data), exp_v[n]);
      check($sformatf("%s valid n%0d", tag, n), int'(out_valid), 1);
      check($sformatf("%s last n%0d", tag, n), int'(out_last), (n == int'(N) - 1) ? 1 : 0);
      check($sformatf("%s overrun n%0d", tag, n), int'(readout_overrun),
            (n > 0 && n - 1 == ov_at) ? 1 : 0);
      if (n == ov_at) start_readout = 1'b1;
      if (feed && n == 6) begin
        in_valid = 1'b1; in_weights = 8'h01; in_data = 8'd3; in_data_signed = 1'b1;
      end
      if (feed && n == 7) begin
        in_valid = 1'b1; in_weights = 8'h00; in_data = 8'd4; in_data_signed = 1'b1;
      end
      step();
      start_readout = 1'b0;
      in_valid      = 1'b0;
    end
    check($sformatf("%s valid after", tag), int'(out_valid), 0);
    check($sformatf("%s last after", tag), int'(out_last), 0);
    check($sformatf("%s overrun after", tag), int'(readout_overrun),
          (ov_at == int'(N) - 1) ? 1 : 0);
  endtask

  task automatic load_t2();
    beat(8'h55, 8'd10, 1'b1);
    beat(8'hFF, 8'd20, 1'b1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int k = 0; k < int'(N); k++) begin
      zeros[k] = 0; e4[k] = 0; e4b[k] = 0; e5n[k] = 0;
    end
    // Rows 0-3 weight +1, rows 4-7 weight -1; cols hold 10 and 20.
    for (int i = 0; i < int'(H); i++) begin
      e2[i*2]     = (i < 4) ? 10 : -10;
      e2[i*2 + 1] = (i < 4) ? 20 : -20;
      e3[i*2]     = (i < 4) ? 2 : 0;
      e3[i*2 + 1] = (i < 4) ? 5 : 0;
    end
    e4[0] = 127;  e4[1] = 127;  e4[8] = -128; e4[9] = -128;
    e4b[0] = 127; e4b[1] = 127;
    e5n[0] = 3;   e5n[1] = 4;

    reset = 1'b1; in_weights = '0; in_data = '0; in_data_signed = 1'b1; in_valid = 1'b0;
    clear = 1'b0; start_readout = 1'b0; shift = '0; relu = 1'b0; out_ready = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset valid", int'(out_valid), 0);
    check("reset last", int'(out_last), 0);
    check("reset data", int'(out_data), 0);
    check("reset overrun", int'(readout_overrun), 0);

    start_ro(0, 1'b0);
    drain("t1", zeros, -1, -1, 1'b0);

    load_t2();
    start_ro(0, 1'b0);
    drain("t2", e2, -1, -1, 1'b0);

    load_t2();
    start_ro(2, 1'b1);
    drain("t3", e3, -1, -1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      beat(8'h01, 8'd127, 1'b1);
      beat(8'h03, 8'd127, 1'b1);
    end
    start_ro(0, 1'b0);
    drain("t4sat", e4, -1, -1, 1'b0);

    beat(8'h01, 8'hFF, 1'b0);
    beat(8'h00, 8'hFF, 1'b0);
    start_ro(1, 1'b0);
    drain("t4uns", e4b, -1, -1, 1'b0);

    load_t2();
    start_ro(0, 1'b0);
    drain("t5", e2, 3, 8, 1'b1);
    start_ro(0, 1'b0);
    drain("t5next", e5n, -1, -1, 1'b0);

    beat(8'hFF, 8'd50, 1'b1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    load_t2();
    start_ro(0, 1'b0);
    drain("t6clr", e2, -1, -1, 1'b0);

    beat(8'h55, 8'd10, 1'b1);
    in_valid = 1'b1; in_weights = 8'hFF; in_data = 8'd20; in_data_signed = 1'b1;
    start_readout = 1'b1; shift = '0; relu = 1'b0;
    step();
    in_valid = 1'b0; start_readout = 1'b0;
    drain("t6same", e2, -1, -1, 1'b0);
    start_ro(0, 1'b0);
    drain("t6after", zeros, -1, -1, 1'b0);

    load_t2();
    start_ro(0, 1'b0);
    for (int k = 0; k < 5; k++) step();
    check("t6rst data n5", $signed(out_data), e2[5]);
    check("t6rst valid n5", int'(out_valid), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6rst valid", int'(out_valid), 0);
    check("t6rst data", int'(out_data), 0);
    check("t6rst last", int'(out_last), 0);
    start_ro(0, 1'b0);
    drain("t6post", zeros, -1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
